// File: rtl/img_pkg.sv
// Shared types and constants for the AXI4-Stream test-pattern generator.
package img_pkg;

   localparam int unsigned SIZE_W_DEF = 12;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LINE   = 2'd1,
      HBLANK = 2'd2
   } state_t;

   localparam logic [1:0] PAT_XRAMP = 2'd0;
   localparam logic [1:0] PAT_YRAMP = 2'd1;
   localparam logic [1:0] PAT_CHECK = 2'd2;
   localparam logic [1:0] PAT_FCNT  = 2'd3;

endpackage

// File: rtl/axis_img_pix.sv
// Combinational pixel formatter: picks an 8-bit value from the pattern rule
// and replicates it across every byte of tdata. Needs SIZE_W >= 8.
module axis_img_pix
   import img_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 24,
   parameter int unsigned SIZE_W     = SIZE_W_DEF
) (
   input  logic [SIZE_W-1:0]     x,
   input  logic [SIZE_W-1:0]     y,
   input  logic [7:0]            fcnt,
   input  logic [1:0]            pattern_sel,
   output logic [DATA_WIDTH-1:0] tdata_c
);

   localparam int unsigned NBYTES = DATA_WIDTH / 8;

   logic [7:0] pix;

   // Select the pattern byte and fan it out to all lanes.
   always_comb begin
      pix = 8'h00;
      case (pattern_sel)
         PAT_XRAMP: pix = x[7:0];
         PAT_YRAMP: pix = y[7:0];
         PAT_CHECK: pix = (x[4] ^ y[4]) ? 8'hFF : 8'h00;
         PAT_FCNT:  pix = fcnt;
         default:   pix = 8'h00;
      endcase
      tdata_c = {NBYTES{pix}};
   end

endmodule

// File: rtl/axis_img_gen.sv
// AXI4-Stream video test-pattern source with per-frame shadowed configuration,
// inter-line blanking and back-to-back frame generation.
module axis_img_gen
   import img_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 24,
   parameter int unsigned SIZE_W     = SIZE_W_DEF,
   parameter int unsigned BLANK_W    = 8
) (
   input  logic                  m_axis_aclk,
   input  logic                  m_axis_areset,
   input  logic                  enable,
   input  logic [SIZE_W-1:0]     img_hsize,
   input  logic [SIZE_W-1:0]     img_vsize,
   input  logic [BLANK_W-1:0]    hblank,
   input  logic [1:0]            pattern_sel,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tuser,
   output logic                  m_axis_tlast,
   output logic                  frame_done,
   output logic                  busy
);

   state_t               state_q, state_n;
   logic [SIZE_W-1:0]    x_q, x_n, y_q, y_n;
   logic [SIZE_W-1:0]    hs_q, hs_n, vs_q, vs_n;
   logic [BLANK_W-1:0]   hb_q, hb_n, blank_q, blank_n;
   logic [1:0]           pat_q, pat_n;
   logic [7:0]           fcnt_q, fcnt_n;
   logic                 tvalid_q, tvalid_n, tuser_q, tuser_n, tlast_q, tlast_n;
   logic                 done_q, done_n, busy_q, busy_n;
   logic [DATA_WIDTH-1:0] tdata_q, pix_c;

   logic start_ok, load, x_last, y_last, hshake;

   assign start_ok = enable && (img_hsize != '0) && (img_vsize != '0);
   assign x_last   = (x_q == hs_q - SIZE_W'(1));
   assign y_last   = (y_q == vs_q - SIZE_W'(1));
   assign hshake   = tvalid_q && m_axis_tready;

   // Pixel data for the beat that will be presented next cycle.
   axis_img_pix #(
      .DATA_WIDTH (DATA_WIDTH),
      .SIZE_W     (SIZE_W)
   ) u_pix (
      .x           (x_n),
      .y           (y_n),
      .fcnt        (fcnt_n),
      .pattern_sel (pat_n),
      .tdata_c     (pix_c)
   );

   // Next-state, counter and output decode.
   always_comb begin
      state_n  = state_q;
      x_n      = x_q;
      y_n      = y_q;
      hs_n     = hs_q;
      vs_n     = vs_q;
      hb_n     = hb_q;
      pat_n    = pat_q;
      blank_n  = blank_q;
      fcnt_n   = fcnt_q;
      tvalid_n = tvalid_q;
      tuser_n  = tuser_q;
      tlast_n  = tlast_q;
      busy_n   = busy_q;
      done_n   = 1'b0;
      load     = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_ok) load = 1'b1;
         end
         LINE: begin
            if (hshake) begin
               if (!x_last) begin
                  x_n     = x_q + SIZE_W'(1);
                  tuser_n = 1'b0;
                  tlast_n = (x_q + SIZE_W'(1) == hs_q - SIZE_W'(1));
               end else if (!y_last) begin
                  x_n     = '0;
                  y_n     = y_q + SIZE_W'(1);
                  tuser_n = 1'b0;
                  tlast_n = (hs_q == SIZE_W'(1));
                  if (hb_q != '0) begin
                     state_n  = HBLANK;
                     tvalid_n = 1'b0;
                     blank_n  = hb_q - BLANK_W'(1);
                  end
               end else begin
                  done_n = 1'b1;
                  fcnt_n = fcnt_q + 8'd1;
                  x_n    = '0;
                  y_n    = '0;
                  if (start_ok) begin
                     load = 1'b1;
                  end else begin
                     state_n  = IDLE;
                     tvalid_n = 1'b0;
                     tuser_n  = 1'b0;
                     tlast_n  = 1'b0;
                     busy_n   = 1'b0;
                  end
               end
            end
         end
         HBLANK: begin
            if (blank_q == '0) begin
               state_n  = LINE;
               tvalid_n = 1'b1;
            end else begin
               blank_n = blank_q - BLANK_W'(1);
            end
         end
         default: state_n = IDLE;
      endcase

      // Frame start: shadow the live configuration and present beat (0,0).
      if (load) begin
         state_n  = LINE;
         hs_n     = img_hsize;
         vs_n     = img_vsize;
         hb_n     = hblank;
         pat_n    = pattern_sel;
         x_n      = '0;
         y_n      = '0;
         tvalid_n = 1'b1;
         tuser_n  = 1'b1;
         tlast_n  = (img_hsize == SIZE_W'(1));
         busy_n   = 1'b1;
      end
   end

   // State and datapath registers.
   always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
      if (m_axis_areset) begin
         state_q  <= IDLE;
         x_q      <= '0;
         y_q      <= '0;
         hs_q     <= '0;
         vs_q     <= '0;
         hb_q     <= '0;
         pat_q    <= '0;
         blank_q  <= '0;
         fcnt_q   <= '0;
         tvalid_q <= 1'b0;
         tuser_q  <= 1'b0;
         tlast_q  <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         tdata_q  <= '0;
      end else begin
         state_q  <= state_n;
         x_q      <= x_n;
         y_q      <= y_n;
         hs_q     <= hs_n;
         vs_q     <= vs_n;
         hb_q     <= hb_n;
         pat_q    <= pat_n;
         blank_q  <= blank_n;
         fcnt_q   <= fcnt_n;
         tvalid_q <= tvalid_n;
         tuser_q  <= tuser_n;
         tlast_q  <= tlast_n;
         done_q   <= done_n;
         busy_q   <= busy_n;
         tdata_q  <= pix_c;
      end
   end

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tuser  = tuser_q;
   assign m_axis_tlast  = tlast_q;
   assign frame_done    = done_q;
   assign busy          = busy_q;

endmodule
